mux4_1: RTL and testbench

- 4-to-1 multiplexer; selects one of four data lanes onto a single output.
- Combinational path for zero-latency datapath use.
- Registered copy of the output for timing-closed consumers.
- Used as a leaf selection cell in control/datapath logic; one clock domain.

---
 rtl/mux4_1.sv | 66 ++++++
 tb/tb_mux4_1.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_1.sv
// 4-to-1 lane multiplexer with a zero-latency output and an enable-gated registered copy.
// Optional per-lane select counters are built when MUX4_1_SEL_STATS_EN is defined.
module mux4_1 #(
  parameter int LANE_W = 1
) (
  input  logic [4*LANE_W-1:0] in,
  input  logic [1:0]          sel,
  output logic [LANE_W-1:0]   out,
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [LANE_W-1:0]   out_q
`ifdef MUX4_1_SEL_STATS_EN
  ,
  output logic [31:0]         sel_cnt
`endif
);

  logic [LANE_W-1:0] sel_s;
  logic [LANE_W-1:0] out_q_r;

  // Lane selection; the default arm keeps the decode full so no latch can form.
  always_comb begin
    sel_s = {LANE_W{1'b0}};
    case (sel)
      2'b00:   sel_s = in[0*LANE_W +: LANE_W];
      2'b01:   sel_s = in[1*LANE_W +: LANE_W];
      2'b10:   sel_s = in[2*LANE_W +: LANE_W];
      2'b11:   sel_s = in[3*LANE_W +: LANE_W];
      default: sel_s = {LANE_W{1'b0}};
    endcase
  end

  assign out = sel_s;

  // Registered copy of the selected lane, captured only when en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_r <= {LANE_W{1'b0}};
    end else if (en) begin
      out_q_r <= sel_s;
    end else begin
      out_q_r <= out_q_r;
    end
  end

  assign out_q = out_q_r;

`ifdef MUX4_1_SEL_STATS_EN
  logic [3:0][7:0] cnt_r;

  // Per-lane select counters; they saturate so long runs never alias back to small counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {32{1'b0}};
    end else if (en && (cnt_r[sel] != 8'hFF)) begin
      cnt_r[sel] <= cnt_r[sel] + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sel_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_mux4_1.sv
// Scoreboard bench for mux4_1: stimulus queues expected values, a monitor pops and compares.
module tb_mux4_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] in = 4'h0;
  logic [1:0] sel = 2'b00;
  logic       out;
  logic       out_q;

  logic [15:0] in4 = 16'h0000;
  logic [1:0]  sel4 = 2'b00;
  logic [3:0]  out4;
  logic [3:0]  out_q4;

`ifdef MUX4_1_SEL_STATS_EN
  logic [31:0] sel_cnt;
  logic [31:0] sel_cnt4;
`endif

  always #5 clk = ~clk;

  mux4_1 #(.LANE_W(1)) dut (
    .in(in), .sel(sel), .out(out),
    .clk(clk), .rst_n(rst_n), .en(en), .out_q(out_q)
`ifdef MUX4_1_SEL_STATS_EN
    , .sel_cnt(sel_cnt)
`endif
  );

  mux4_1 #(.LANE_W(4)) dut4 (
    .in(in4), .sel(sel4), .out(out4),
    .clk(clk), .rst_n(rst_n), .en(1'b0), .out_q(out_q4)
`ifdef MUX4_1_SEL_STATS_EN
    , .sel_cnt(sel_cnt4)
`endif
  );

  typedef struct {
    int          kind;   // 0: out, 1: out_q, 2: out4, 3: sel_cnt
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  event smp;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic expect_val(input int kind, input logic [31:0] e, input string nm);
    exp_t x;
    x.kind = kind;
    x.exp  = e;
    x.name = nm;
    q.push_back(x);
    -> smp;
    #1;
  endtask

  // Monitor: pop the next expectation and compare it with the DUT output it names.
  initial begin
    exp_t x;
    logic [31:0] act;
    forever begin
      @(smp);
      if (q.size() != 0) begin
        x = q.pop_front();
        act = 32'h0;
        case (x.kind)
          0: act = {31'h0, out};
          1: act = {31'h0, out_q};
          2: act = {28'h0, out4};
`ifdef MUX4_1_SEL_STATS_EN
          3: act = sel_cnt;
`endif
          default: act = 32'hDEAD_BEEF;
        endcase
        n_chk = n_chk + 1;
        if (act === x.exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", x.name, act, x.exp);
      end
    end
  end

  initial begin
    int v;
    // Reset state
    #12;
    expect_val(1, 32'h0, "reset_out_q");
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive combinational sweep
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) begin
        v = i;
        sel = s[1:0];
        in  = v[3:0];
        #4;
        expect_val(0, {31'h0, v[s]}, $sformatf("sweep_s%0d_in%0h", s, i));
        #5;
      end
    end

    // Spot checks
    sel = 2'b00; in = 4'b0101; #2; expect_val(0, 32'h1, "spot_sel0_0101");
    sel = 2'b01; in = 4'b0101; #2; expect_val(0, 32'h0, "spot_sel1_0101");
    sel = 2'b11; in = 4'b1000; #2; expect_val(0, 32'h1, "spot_sel3_1000");
    sel = 2'b10; in = 4'b1011; #2; expect_val(0, 32'h0, "spot_sel2_1011");

    // Registered path
    @(negedge clk);
    sel = 2'b10; in = 4'b0100; en = 1'b1;
    @(negedge clk);
    expect_val(1, 32'h1, "reg_capture");
    in = 4'b0000; en = 1'b0;
    @(negedge clk);
    expect_val(1, 32'h1, "reg_hold");
    expect_val(0, 32'h0, "reg_hold_out");
    en = 1'b1;
    @(negedge clk);
    expect_val(1, 32'h0, "reg_recapture");

    // Asynchronous reset between edges
    sel = 2'b00; in = 4'b0001; en = 1'b1;
    @(negedge clk);
    expect_val(1, 32'h1, "pre_reset_q");
    en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    expect_val(1, 32'h0, "async_clear");
    expect_val(0, 32'h1, "out_in_reset");
    in = 4'b0000;
    #1;
    expect_val(0, 32'h0, "out_tracks_in_reset");
    @(negedge clk);
    in = 4'b0001;
    rst_n = 1'b1;
    @(negedge clk);
    expect_val(1, 32'h0, "release_no_en");
    en = 1'b1;
    @(negedge clk);
    expect_val(1, 32'h1, "release_first_en");
    en = 1'b0;

`ifdef MUX4_1_SEL_STATS_EN
    // Selection counters: increment, saturation, reset
    rst_n = 1'b0;
    #2;
    expect_val(3, 32'h0, "cnt_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sel = 2'b10; en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    expect_val(3, 32'h0003_0000, "cnt_lane2_x3");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    sel = 2'b01; en = 1'b1;
    repeat (300) @(negedge clk);
    en = 1'b0;
    expect_val(3, 32'h0000_FF00, "cnt_saturate");
    rst_n = 1'b0;
    #2;
    expect_val(3, 32'h0, "cnt_reset_after_sat");
    rst_n = 1'b1;
`endif

    // Wide lanes
    in4 = 16'hA5C3;
    sel4 = 2'b11; #2; expect_val(2, 32'hA, "w4_sel3");
    sel4 = 2'b00; #2; expect_val(2, 32'h3, "w4_sel0");
    sel4 = 2'b01; #2; expect_val(2, 32'hC, "w4_sel1");
    sel4 = 2'b10; #2; expect_val(2, 32'h5, "w4_sel2");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && q.size() != 0; k++) #1;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      n_chk = n_chk + q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
